uart_tile_deframer: RTL and testbench
=====================================

Name: uart_tile_deframer

Overview:
- Receive-side framing stage between `uart_rx` and the L3 read-completion FIFO.
- Consumes the byte stream `uart_rx_valid`/`uart_rx_data` and validates sync, type and checksum.
- Assembles 36 payload bytes into one 288-bit matrix tile and emits a one-cycle strobe that drives the L3 FIFO `i_wr`/`i_data`.
- Malformed, corrupted or stalled frames are dropped and counted; they never reach the L3 FIFO.

Parameters:
- TILE_BITS, 288, payload width in bits (18*16); must be a multiple of 8; NBYTES = TILE_BITS/8 = 36.
- SYNC_BYTE, 8'hA5, frame start marker.
- TYPE_MEM_READ, 8'h01, the only accepted frame type.
- TIMEOUT_CYCLES, 60000, maximum clk cycles allowed between consecutive bytes inside a frame.

Ports:
- clk  in  1  system clock.
- reset  in  1  synchronous, active-high reset.
- rx_valid  in  1  one-cycle pulse; rx_data is valid this cycle.
- rx_data  in  8  received byte.
- tile_stb  out  1  one-cycle pulse; tile holds a newly validated payload.
- tile  out  TILE_BITS  last validated payload; held stable between strobes.
- frame_err  out  1  one-cycle pulse on any dropped frame.
- err_count  out  8  saturating count of dropped frames.
- busy  out  1  high while in any state other than IDLE.

Behaviour:
- Reset and clocking: one clock, synchronous active-high reset, all flops on posedge clk.
- Reset values: tile_stb=0, tile=0, frame_err=0, err_count=0, busy=0, state=IDLE, byte_idx=0, checksum accumulator=0, timeout counter=0.
- Reset mid-frame discards the partial frame without a frame_err pulse.
- State machine and transitions; bytes are consumed only on cycles with rx_valid=1:
  - IDLE: rx_data==SYNC_BYTE -> TYPE. Any other byte is ignored silently; no error.
  - TYPE: rx_data==TYPE_MEM_READ -> PAYLOAD, checksum:=rx_data, byte_idx:=0. Any other value -> IDLE with frame_err.
  - PAYLOAD: shift register <= {shift[TILE_BITS-9:0], rx_data}, so the first payload byte ends in tile[287:280]. Checksum ^= rx_data, byte_idx++. The byte with byte_idx==NBYTES-1 -> CHECK.
  - CHECK: rx_data==checksum -> load tile from the shift register, tile_stb=1 next cycle, -> IDLE. Mismatch -> IDLE with frame_err; tile unchanged.
- Latency: tile_stb rises exactly 1 cycle after the clock edge that samples the checksum byte; it is high for exactly 1 cycle.
- tile changes only on the cycle tile_stb rises.
- Checksum = XOR of the type byte and all NBYTES payload bytes.
- Inter-byte timeout:
  - The counter runs only in TYPE/PAYLOAD/CHECK and clears on every accepted byte.
  - Reaching TIMEOUT_CYCLES-1 without a byte -> IDLE with frame_err.
  - If rx_valid arrives on that same cycle, the byte wins and no timeout fires.
- Errors:
  - Every error pulse increments err_count, saturating at 255; frame_err is high 1 cycle.
  - Only one error is raised per frame.
- A SYNC_BYTE value appearing inside PAYLOAD or CHECK is treated as data; there is no resynchronisation.
- Back-to-back frames: a sync byte arriving the cycle after the CHECK byte is accepted normally, including while tile_stb is high.
- No backpressure: the consumer must accept every tile_stb. The L3 FIFO overflow is detected downstream by its o_err.
- busy=1 in TYPE/PAYLOAD/CHECK.

Test Plan:
- Good frame: A5, 01, payload bytes 0x00..0x23, checksum (0x01 ^ XOR of 0x00..0x23 = 0x01) -> tile_stb one cycle after the last byte; tile[287:280]=00, tile[7:0]=23; err_count=0.
- Bad checksum: same frame with checksum 0x02 -> no tile_stb; frame_err one cycle; err_count=1; tile unchanged from the previous good frame.
- Bad type: A5, 07 -> frame_err, state back to IDLE; a following good frame is received correctly.
- Timeout: A5, 01, 10 payload bytes, then silence for 60000 cycles -> frame_err at cycle 59999 after the last byte; busy falls. A byte at cycle 59999 instead produces no error.
- Noise and back-to-back frames: bytes 00, FF, 13 before a frame -> ignored, no error. Two good frames separated by zero idle cycles -> two tile_stb pulses, each carrying the correct payload.
- Reset and saturation: reset asserted after 20 payload bytes -> busy=0, no stb, no error; the next good frame works. 300 bad-type frames -> err_count=255, held.

Source files
------------

// File: rtl/uart_tile_deframer.sv
// Validates A5/type/payload/checksum UART frames into 288-bit tiles; tile_stb 1 cycle after the checksum byte.
// No backpressure: every strobe must be taken; bad, corrupt or stalled frames are dropped and counted.
module uart_tile_deframer #(
   parameter int          TILE_BITS      = 288,
   parameter logic [7:0]  SYNC_BYTE      = 8'hA5,
   parameter logic [7:0]  TYPE_MEM_READ  = 8'h01,
   parameter int          TIMEOUT_CYCLES = 60000
) (
   input  logic                 clk,
   input  logic                 reset,
   input  logic                 rx_valid,
   input  logic [7:0]           rx_data,
   output logic                 tile_stb,
   output logic [TILE_BITS-1:0] tile,
   output logic                 frame_err,
   output logic [7:0]           err_count,
   output logic                 busy
);

   localparam int NBYTES = TILE_BITS / 8;
   localparam int IDX_W  = $clog2(NBYTES);
   localparam int TMO_W  = $clog2(TIMEOUT_CYCLES);

   typedef enum logic [1:0] {
      IDLE,
      TYPE,
      PAYLOAD,
      CHECK
   } state_t;

   state_t               state;
   logic [IDX_W-1:0]     byte_idx;
   logic [7:0]           checksum;
   logic [TMO_W-1:0]     tmo_cnt;
   logic [TILE_BITS-1:0] shift;
   logic                 timeout_hit;
   logic                 err_now;

   // The counter would reach TIMEOUT_CYCLES-1 on this edge; an arriving byte takes priority.
   assign timeout_hit = (state != IDLE) && !rx_valid
                        && (tmo_cnt == TMO_W'(TIMEOUT_CYCLES - 2));

   always_comb begin
      err_now = 1'b0;
      case (state)
         TYPE:    err_now = rx_valid && (rx_data != TYPE_MEM_READ);
         CHECK:   err_now = rx_valid && (rx_data != checksum);
         default: err_now = 1'b0;
      endcase
      if (timeout_hit) begin
         err_now = 1'b1;
      end
   end

   assign busy = (state != IDLE);

   always_ff @(posedge clk) begin
      if (reset) begin
         state     <= IDLE;
         byte_idx  <= '0;
         checksum  <= '0;
         tmo_cnt   <= '0;
         shift     <= '0;
         tile      <= '0;
         tile_stb  <= 1'b0;
         frame_err <= 1'b0;
         err_count <= '0;
      end else begin
         tile_stb  <= 1'b0;
         frame_err <= err_now;
         if (err_now && (err_count != 8'hFF)) begin
            err_count <= err_count + 8'd1;
         end

         if (state == IDLE || rx_valid) begin
            tmo_cnt <= '0;
         end else begin
            tmo_cnt <= tmo_cnt + 1'b1;
         end

         case (state)
            IDLE: begin
               if (rx_valid && rx_data == SYNC_BYTE) begin
                  state <= TYPE;
               end
            end
            TYPE: begin
               if (rx_valid) begin
                  if (rx_data == TYPE_MEM_READ) begin
                     state    <= PAYLOAD;
                     checksum <= rx_data;
                     byte_idx <= '0;
                  end else begin
                     state <= IDLE;
                  end
               end
            end
            PAYLOAD: begin
               if (rx_valid) begin
                  shift    <= {shift[TILE_BITS-9:0], rx_data};
                  checksum <= checksum ^ rx_data;
                  if (byte_idx == IDX_W'(NBYTES - 1)) begin
                     state    <= CHECK;
                     byte_idx <= '0;
                  end else begin
                     byte_idx <= byte_idx + 1'b1;
                  end
               end
            end
            CHECK: begin
               if (rx_valid) begin
                  if (rx_data == checksum) begin
                     tile     <= shift;
                     tile_stb <= 1'b1;
                  end
                  state <= IDLE;
               end
            end
            default: state <= IDLE;
         endcase

         if (timeout_hit) begin
            state <= IDLE;
         end
      end
   end

endmodule

// File: tb/tb_uart_tile_deframer.sv
// Directed frames against a queue-based frame model; outputs compared every cycle plus literal spot checks.
module tb_uart_tile_deframer;

   localparam int TB  = 288;
   localparam int NB  = TB / 8;
   localparam int TMO = 200;

   logic          clk = 1'b0;
   logic          reset;
   logic          rx_valid;
   logic [7:0]    rx_data;
   logic          tile_stb;
   logic [TB-1:0] tile;
   logic          frame_err;
   logic [7:0]    err_count;
   logic          busy;

   int total = 0;
   int bad   = 0;

   uart_tile_deframer #(
      .TILE_BITS      (TB),
      .TIMEOUT_CYCLES (TMO)
   ) dut (
      .clk       (clk),
      .reset     (reset),
      .rx_valid  (rx_valid),
      .rx_data   (rx_data),
      .tile_stb  (tile_stb),
      .tile      (tile),
      .frame_err (frame_err),
      .err_count (err_count),
      .busy      (busy)
   );

   always #5 clk = ~clk;

   // Frame model: bytes of the frame in progress, idle gap length, expected outputs.
   int            m_stage;
   int            m_gap;
   logic [7:0]    m_pay[$];
   logic          exp_stb;
   logic          exp_err;
   logic          exp_busy;
   logic [TB-1:0] exp_tile;
   int            exp_cnt;

   initial begin
      logic       m_fail;
      logic [7:0] cs;
      m_stage = 0; m_gap = 0; exp_stb = 0; exp_err = 0; exp_busy = 0; exp_tile = '0; exp_cnt = 0;
      forever begin
         @(posedge clk);
         m_fail  = 1'b0;
         exp_stb = 1'b0;
         exp_err = 1'b0;
         if (reset) begin
            m_stage = 0; m_gap = 0; m_pay.delete(); exp_tile = '0; exp_cnt = 0;
         end else if (rx_valid) begin
            m_gap = 0;
            if (m_stage == 0) begin
               if (rx_data == 8'hA5) m_stage = 1;
            end else if (m_stage == 1) begin
               if (rx_data == 8'h01) begin
                  m_stage = 2;
                  m_pay.delete();
               end else m_fail = 1'b1;
            end else if (m_pay.size() < NB) begin
               m_pay.push_back(rx_data);
            end else begin
               cs = 8'h01;
               foreach (m_pay[i]) cs ^= m_pay[i];
               if (rx_data == cs) begin
                  for (int i = 0; i < NB; i++) exp_tile[TB-1-8*i -: 8] = m_pay[i];
                  exp_stb = 1'b1;
               end else m_fail = 1'b1;
               m_stage = 0;
            end
         end else if (m_stage > 0) begin
            m_gap++;
            if (m_gap == TMO - 1) m_fail = 1'b1;
         end
         if (m_fail) begin
            m_stage = 0;
            m_gap   = 0;
            exp_err = 1'b1;
            if (exp_cnt < 255) exp_cnt++;
         end
         exp_busy = (m_stage > 0);
      end
   end

   task automatic check(input string name, input logic [TB-1:0] act, input logic [TB-1:0] want);
      total++;
      if (act !== want) begin
         bad++;
         $display("FAIL %s got=%h want=%h", name, act, want);
      end
   endtask

   task automatic lit(input string name, input logic [TB-1:0] act, input logic [TB-1:0] want);
      #1;
      check(name, act, want);
   endtask

   initial begin
      @(posedge clk);
      forever begin
         @(negedge clk);
         check("tile_stb", TB'(tile_stb), TB'(exp_stb));
         check("frame_err", TB'(frame_err), TB'(exp_err));
         check("busy", TB'(busy), TB'(exp_busy));
         check("err_count", TB'(err_count), TB'(exp_cnt));
         check("tile", tile, exp_tile);
      end
   end

   logic [7:0] pl[NB];

   task automatic make_pl(input int mul, input int add);
      for (int i = 0; i < NB; i++) pl[i] = 8'(i * mul + add);
   endtask

   function automatic logic [7:0] csum_of();
      logic [7:0] c = 8'h01;
      for (int i = 0; i < NB; i++) c ^= pl[i];
      return c;
   endfunction

   task automatic send_byte(input logic [7:0] b);
      rx_valid = 1'b1;
      rx_data  = b;
      @(negedge clk);
      rx_valid = 1'b0;
   endtask

   task automatic send_frame(input logic [7:0] csum_flip);
      send_byte(8'hA5);
      send_byte(8'h01);
      for (int i = 0; i < NB; i++) send_byte(pl[i]);
      send_byte(csum_of() ^ csum_flip);
   endtask

   initial begin
      reset    = 1'b1;
      rx_valid = 1'b0;
      rx_data  = 8'h00;
      repeat (3) @(negedge clk);
      reset = 1'b0;
      lit("reset_busy", TB'(busy), TB'(0));
      lit("reset_tile", tile, '0);
      lit("reset_cnt", TB'(err_count), TB'(0));

      // Noise then a good frame with payload 00..23, checksum 01
      send_byte(8'h00); send_byte(8'hFF); send_byte(8'h13);
      lit("noise_err", TB'(frame_err), TB'(0));
      make_pl(1, 0);
      lit("good_csum_val", TB'(csum_of()), TB'(8'h01));
      send_frame(8'h00);
      lit("good_stb", TB'(tile_stb), TB'(1));
      lit("good_tile_hi", TB'(tile[287:280]), TB'(8'h00));
      lit("good_tile_lo", TB'(tile[7:0]), TB'(8'h23));
      lit("good_cnt", TB'(err_count), TB'(0));

      // Bad checksum (02)
      send_frame(8'h03);
      lit("badcs_stb", TB'(tile_stb), TB'(0));
      lit("badcs_err", TB'(frame_err), TB'(1));
      lit("badcs_cnt", TB'(err_count), TB'(1));
      lit("badcs_tile_lo", TB'(tile[7:0]), TB'(8'h23));

      // Bad type, then a different good frame
      send_byte(8'hA5); send_byte(8'h07);
      lit("badtype_err", TB'(frame_err), TB'(1));
      lit("badtype_busy", TB'(busy), TB'(0));
      make_pl(3, 16);
      send_frame(8'h00);
      lit("after_bt_stb", TB'(tile_stb), TB'(1));
      lit("after_bt_lo", TB'(tile[7:0]), TB'(8'h79));

      // Timeout after 10 payload bytes
      make_pl(5, 7);
      send_byte(8'hA5); send_byte(8'h01);
      for (int i = 0; i < 10; i++) send_byte(pl[i]);
      repeat (TMO - 2) @(negedge clk);
      lit("tmo_pre_err", TB'(frame_err), TB'(0));
      lit("tmo_pre_busy", TB'(busy), TB'(1));
      @(negedge clk);
      lit("tmo_err", TB'(frame_err), TB'(1));
      lit("tmo_busy", TB'(busy), TB'(0));
      lit("tmo_cnt", TB'(err_count), TB'(3));

      // Byte arrives on the last allowed cycle: no timeout, frame completes
      send_byte(8'hA5); send_byte(8'h01);
      for (int i = 0; i < 10; i++) send_byte(pl[i]);
      repeat (TMO - 2) @(negedge clk);
      send_byte(pl[10]);
      lit("tmo_edge_err", TB'(frame_err), TB'(0));
      lit("tmo_edge_busy", TB'(busy), TB'(1));
      for (int i = 11; i < NB; i++) send_byte(pl[i]);
      send_byte(csum_of());
      lit("tmo_edge_stb", TB'(tile_stb), TB'(1));

      // Back-to-back frames, zero idle cycles
      make_pl(1, 8'h40);
      send_frame(8'h00);
      lit("b2b_stb1", TB'(tile_stb), TB'(1));
      make_pl(2, 8'h81);
      send_frame(8'h00);
      lit("b2b_stb2", TB'(tile_stb), TB'(1));
      lit("b2b_hi2", TB'(tile[287:280]), TB'(8'h81));

      // Reset mid-frame
      send_byte(8'hA5); send_byte(8'h01);
      for (int i = 0; i < 20; i++) send_byte(pl[i]);
      reset = 1'b1;
      @(negedge clk);
      reset = 1'b0;
      lit("rst_busy", TB'(busy), TB'(0));
      lit("rst_err", TB'(frame_err), TB'(0));
      lit("rst_stb", TB'(tile_stb), TB'(0));
      make_pl(1, 0);
      send_frame(8'h00);
      lit("rst_next_stb", TB'(tile_stb), TB'(1));

      // Saturation
      for (int k = 0; k < 300; k++) begin
         send_byte(8'hA5); send_byte(8'h07);
      end
      lit("sat_cnt", TB'(err_count), TB'(255));
      send_byte(8'hA5); send_byte(8'h07);
      lit("sat_hold", TB'(err_count), TB'(255));

      repeat (3) @(negedge clk);
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
